// File: rtl/ext_mem_host_if.sv
// ext_mem_host_if: load stream, dump stream and the two external memory
// ports of the cpu, bundled for the host driver (master) and its peer (slave).
interface ext_mem_host_if;
    // Load stream (host link -> driver)
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    // Dump stream (driver -> host link)
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    // Instruction memory port
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    // Data memory port
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;

    modport master (
        input  in_valid, in_data, out_ready, rdata_ext_2,
        output in_ready, out_valid, out_data,
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );

    modport slave (
        output in_valid, in_data, out_ready, rdata_ext_2,
        input  in_ready, out_valid, out_data,
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2
    );
endinterface

// File: rtl/ext_mem_host.sv
// ext_mem_host: host-side driver for the cpu's external memory ports.
// Loads a program and a data image from a valid/ready stream, enables the
// core for a programmed number of cycles, then (optionally) streams data
// memory back out.
// Build option: define EXT_MEM_HOST_DUMP_EN to include the data memory dump;
// without it the session ends right after the run phase.
module ext_mem_host #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_instr,
    input  logic [CNT_W-1:0]  n_data,
    input  logic [31:0]       run_cycles,
    output logic              cpu_enable,
    output logic              busy,
    output logic              done,
    ext_mem_host_if.master    bus
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD_I   = 3'd1;
    localparam logic [2:0] S_LOAD_D   = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_DUMP_RD  = 3'd4;
    localparam logic [2:0] S_DUMP_CAP = 3'd5;
    localparam logic [2:0] S_DUMP_OUT = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    logic [2:0]       state;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] cnt_i;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      run_len;
    logic [31:0]      run_cnt;

    logic [CNT_W-1:0] n_instr_cl;
    logic [CNT_W-1:0] n_data_cl;
    logic [CNT_W-1:0] idx_inc;
    logic             last_i;
    logic             last_d;

    // Requests larger than the memories are truncated to their depth
    assign n_instr_cl = (n_instr > CNT_W'(IMEM_WORDS)) ? CNT_W'(IMEM_WORDS) : n_instr;
    assign n_data_cl  = (n_data  > CNT_W'(DMEM_WORDS)) ? CNT_W'(DMEM_WORDS) : n_data;

    assign idx_inc = idx + CNT_W'(1);
    assign last_i  = (idx == cnt_i - CNT_W'(1));
    assign last_d  = (idx == cnt_d - CNT_W'(1));

    // Status and stream-ready decode straight from the state
    assign bus.in_ready = (state == S_LOAD_I) || (state == S_LOAD_D);
    assign bus.ren_ext  = 1'b0;
    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign done         = (state == S_DONE);

`ifdef EXT_MEM_HOST_DUMP_EN
    logic        ren_q;
    logic        out_valid_q;
    logic [63:0] out_data_q;

    assign bus.ren_ext_2 = ren_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
`else
    logic unused_dump;

    assign bus.ren_ext_2 = 1'b0;
    assign bus.out_valid = 1'b0;
    assign bus.out_data  = '0;
    assign unused_dump   = ^{bus.out_ready, bus.rdata_ext_2};
`endif

    // Session sequencer: every memory-port output is registered so a word
    // accepted at one edge appears as a one-cycle write pulse in the next cycle
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state           <= S_IDLE;
            idx             <= '0;
            cnt_i           <= '0;
            cnt_d           <= '0;
            run_len         <= '0;
            run_cnt         <= '0;
            cpu_enable      <= 1'b0;
            bus.addr_ext    <= '0;
            bus.wen_ext     <= 1'b0;
            bus.wdata_ext   <= '0;
            bus.addr_ext_2  <= '0;
            bus.wen_ext_2   <= 1'b0;
            bus.wdata_ext_2 <= '0;
`ifdef EXT_MEM_HOST_DUMP_EN
            ren_q           <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
`endif
        end else begin
            bus.wen_ext   <= 1'b0;
            bus.wen_ext_2 <= 1'b0;
`ifdef EXT_MEM_HOST_DUMP_EN
            ren_q         <= 1'b0;
`endif
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cnt_i   <= n_instr_cl;
                        cnt_d   <= n_data_cl;
                        run_len <= run_cycles;
                        run_cnt <= '0;
                        idx     <= '0;
                        if (n_instr_cl != '0)
                            state <= S_LOAD_I;
                        else if (n_data_cl != '0)
                            state <= S_LOAD_D;
                        else
                            state <= S_RUN;
                    end
                end
                S_LOAD_I: begin
                    if (bus.in_valid) begin
                        bus.wen_ext   <= 1'b1;
                        bus.addr_ext  <= {{(62-CNT_W){1'b0}}, idx, 2'b00};
                        bus.wdata_ext <= bus.in_data[31:0];
                        if (last_i) begin
                            idx   <= '0;
                            state <= (cnt_d != '0) ? S_LOAD_D : S_RUN;
                        end else begin
                            idx <= idx_inc;
                        end
                    end
                end
                S_LOAD_D: begin
                    if (bus.in_valid) begin
                        bus.wen_ext_2   <= 1'b1;
                        bus.addr_ext_2  <= {{(61-CNT_W){1'b0}}, idx, 3'b000};
                        bus.wdata_ext_2 <= bus.in_data;
                        if (last_d) begin
                            idx   <= '0;
                            state <= S_RUN;
                        end else begin
                            idx <= idx_inc;
                        end
                    end
                end
                S_RUN: begin
                    // Entered the cycle of the last write pulse; enable rises one cycle later
                    if (run_cnt != run_len) begin
                        cpu_enable <= 1'b1;
                        run_cnt    <= run_cnt + 32'd1;
                    end else begin
                        cpu_enable <= 1'b0;
                        idx        <= '0;
`ifdef EXT_MEM_HOST_DUMP_EN
                        if (cnt_d != '0) begin
                            state          <= S_DUMP_RD;
                            ren_q          <= 1'b1;
                            bus.addr_ext_2 <= '0;
                        end else begin
                            state <= S_DONE;
                        end
`else
                        state <= S_DONE;
`endif
                    end
                end
`ifdef EXT_MEM_HOST_DUMP_EN
                S_DUMP_RD: begin
                    state <= S_DUMP_CAP;
                end
                S_DUMP_CAP: begin
                    out_data_q  <= bus.rdata_ext_2;
                    out_valid_q <= 1'b1;
                    state       <= S_DUMP_OUT;
                end
                S_DUMP_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_d) begin
                            state <= S_DONE;
                        end else begin
                            idx            <= idx_inc;
                            ren_q          <= 1'b1;
                            bus.addr_ext_2 <= {{(61-CNT_W){1'b0}}, idx_inc, 3'b000};
                            state          <= S_DUMP_RD;
                        end
                    end
                end
`else
                S_DUMP_RD, S_DUMP_CAP, S_DUMP_OUT: begin
                    state <= S_IDLE;
                end
`endif
            endcase
        end
    end

endmodule

// File: tb/tb_ext_mem_host.sv
// tb_ext_mem_host: randomized session bench for ext_mem_host with a
// transaction-level reference model (expected write lists, enable window,
// dump contents) and a data memory model with one-cycle read latency.
`timescale 1ns/1ps
module tb_ext_mem_host;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             start;
    logic [CNT_W-1:0] n_instr;
    logic [CNT_W-1:0] n_data;
    logic [31:0]      run_cycles;
    logic             cpu_enable;
    logic             busy;
    logic             done;

    ext_mem_host_if bus();

    ext_mem_host #(.IMEM_WORDS(512), .DMEM_WORDS(1024), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .n_instr    (n_instr),
        .n_data     (n_data),
        .run_cycles (run_cycles),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Stimulus words for the next session
    logic [63:0] wi[$];
    logic [63:0] wd[$];

    // Observations
    int           cyc = 0;
    logic [95:0]  iw_q[$];
    logic [127:0] dw_q[$];
    logic [63:0]  out_q[$];
    int en_cnt, en_first, en_last, w_last, overlap, stab_err, stall_cnt;
    int ren_ext_cnt, ren2_cnt, valid_cnt;
    logic        prev_valid, prev_ready;
    logic [63:0] prev_data;
    logic [63:0] dmem [0:1023];
    logic        rd_pend;
    logic [63:0] rd_addr;
    int          ready_mode = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (arst_n) begin
            if (bus.wen_ext) begin
                iw_q.push_back({bus.addr_ext, bus.wdata_ext});
                w_last = cyc;
            end
            if (bus.wen_ext_2) begin
                dw_q.push_back({bus.addr_ext_2, bus.wdata_ext_2});
                w_last = cyc;
                if (bus.addr_ext_2 < 64'd8192) dmem[bus.addr_ext_2[12:3]] = bus.wdata_ext_2;
            end
            if (cpu_enable) begin
                if (en_cnt == 0) en_first = cyc;
                en_last = cyc;
                en_cnt++;
                if (bus.wen_ext || bus.wen_ext_2) overlap++;
            end
            if (bus.ren_ext) ren_ext_cnt++;
            if (bus.ren_ext_2) begin
                ren2_cnt++;
                rd_pend = 1'b1;
                rd_addr = bus.addr_ext_2;
            end
            if (bus.out_valid) begin
                valid_cnt++;
                if (prev_valid && !prev_ready && bus.out_data !== prev_data) stab_err++;
                if (!bus.out_ready) stall_cnt++;
                else out_q.push_back(bus.out_data);
            end
            prev_valid = bus.out_valid;
            prev_ready = bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    // Data memory read port: answer one cycle after ren_ext_2, garbage otherwise
    initial begin
        bus.rdata_ext_2 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_pend && rd_addr < 64'd8192) begin
                bus.rdata_ext_2 = dmem[rd_addr[12:3]];
                rd_pend = 1'b0;
            end else begin
                bus.rdata_ext_2 = {$urandom, $urandom};
                rd_pend = 1'b0;
            end
        end
    end

    // Dump back-pressure: 0 always ready, 1 random, 2 hold off for 4 valid cycles
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = (stall_cnt >= 4);
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        iw_q.delete(); dw_q.delete(); out_q.delete();
        en_cnt = 0; en_first = 0; en_last = 0; w_last = 0; overlap = 0;
        stab_err = 0; stall_cnt = 0; ren_ext_cnt = 0; ren2_cnt = 0; valid_cnt = 0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0; rd_pend = 1'b0;
    endtask

    task automatic fill(input int ni, input int nd);
        wi.delete(); wd.delete();
        for (int k = 0; k < ni; k++) wi.push_back({$urandom, $urandom});
        for (int k = 0; k < nd; k++) wd.push_back({$urandom, $urandom});
    endtask

    // One session; stall<0 gives random gaps. mode 1 pokes start while busy,
    // mode 2 pulls reset during the run phase and returns.
    task automatic session(input int ni, input int nd, input int rc, input int stall, input int mode);
        int  ci, cd, guard, gap;
        bit  acc;
        ci = (ni > 512) ? 512 : ni;
        cd = (nd > 1024) ? 1024 : nd;
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; n_instr = CNT_W'(ni); n_data = CNT_W'(nd); run_cycles = rc;
        @(posedge clk); #1;
        start = 1'b0; n_instr = CNT_W'($urandom); n_data = CNT_W'($urandom); run_cycles = $urandom;
        for (int k = 0; k < ci + cd; k++) begin
            gap = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    bus.in_valid = 1'b0; bus.in_data = {$urandom, $urandom};
                    @(posedge clk); #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = (k < ci) ? wi[k] : wd[k - ci];
            guard = 0;
            do begin
                @(negedge clk); acc = bus.in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!acc && guard < 200);
            if (!acc) begin
                check("in_ready_timeout", 64'(acc), 64'd1);
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (mode != 0) begin
            guard = 0;
            while (!cpu_enable && guard < 500) begin @(negedge clk); guard++; end
            check("enable_seen", 64'(cpu_enable), 64'd1);
        end
        if (mode == 1) begin
            @(posedge clk); #1;
            start = 1'b1; n_instr = 16'd7; n_data = 16'd7; run_cycles = 32'd99;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (mode == 2) begin
            @(posedge clk); #2;
            arst_n = 1'b0;
            #1;
            check("abort_enable", 64'(cpu_enable), 64'd0);
            check("abort_busy", 64'(busy), 64'd0);
            check("abort_done", 64'(done), 64'd0);
            check("abort_in_ready", 64'(bus.in_ready), 64'd0);
            check("abort_addr_ext", bus.addr_ext, 64'd0);
            check("abort_wdata_ext_2", bus.wdata_ext_2, 64'd0);
            @(negedge clk);
            arst_n = 1'b1;
            @(negedge clk);
            check("abort_idle", 64'(busy || done), 64'd0);
            return;
        end
        guard = 0;
        while (!done && guard < 20000) begin @(negedge clk); guard++; end
        check("done_reached", 64'(done), 64'd1);
        repeat (2) @(negedge clk);
        check("done_held", 64'(done), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("iw_count", 64'(iw_q.size()), 64'(ci));
        for (int k = 0; k < ci && k < iw_q.size(); k++) begin
            check("iw_addr", iw_q[k][95:32], 64'(4 * k));
            check("iw_data", 64'(iw_q[k][31:0]), 64'(wi[k][31:0]));
        end
        check("dw_count", 64'(dw_q.size()), 64'(cd));
        for (int k = 0; k < cd && k < dw_q.size(); k++) begin
            check("dw_addr", dw_q[k][127:64], 64'(8 * k));
            check("dw_data", dw_q[k][63:0], wd[k]);
        end
        check("en_cycles", 64'(en_cnt), 64'(rc));
        if (rc > 0) check("en_contig", 64'(en_last - en_first + 1), 64'(rc));
        if (rc > 0 && ci + cd > 0) check("en_after_write", 64'(en_first), 64'(w_last + 1));
        check("en_overlap", 64'(overlap), 64'd0);
        check("ren_ext_zero", 64'(ren_ext_cnt), 64'd0);
`ifdef EXT_MEM_HOST_DUMP_EN
        check("dump_count", 64'(out_q.size()), 64'(cd));
        for (int k = 0; k < cd && k < out_q.size(); k++) check("dump_data", out_q[k], wd[k]);
        check("dump_reads", 64'(ren2_cnt), 64'(cd));
        check("dump_stable", 64'(stab_err), 64'd0);
`else
        check("no_dump_valid", 64'(valid_cnt), 64'd0);
        check("no_dump_ren", 64'(ren2_cnt), 64'd0);
        check("no_dump_data", bus.out_data, 64'd0);
`endif
    endtask

    initial begin
        int s, d, guard;
        arst_n = 1'b1; start = 1'b0; n_instr = '0; n_data = '0; run_cycles = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        clear_mon();
        #2 arst_n = 1'b0;
        #20;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_cpu_enable", 64'(cpu_enable), 64'd0);
        check("rst_wen_ext", 64'(bus.wen_ext), 64'd0);
        check("rst_wen_ext_2", 64'(bus.wen_ext_2), 64'd0);
        check("rst_ren_ext", 64'(bus.ren_ext), 64'd0);
        check("rst_ren_ext_2", 64'(bus.ren_ext_2), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_addr_ext", bus.addr_ext, 64'd0);
        check("rst_addr_ext_2", bus.addr_ext_2, 64'd0);
        check("rst_wdata_ext", 64'(bus.wdata_ext), 64'd0);
        check("rst_wdata_ext_2", bus.wdata_ext_2, 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);

        // Small program, no data, no run
        wi = '{64'hFFFF0000_00500093, 64'h12345678_00A00113, 64'h0_002081B3};
        wd.delete();
        session(3, 0, 0, 0, 0);

        // Data load with gaps between words and a 5-cycle run
        wi.delete();
        wd = '{64'h11, 64'h22};
        session(0, 2, 5, 2, 0);

        // Dump with a 4-cycle stall on the first word
        ready_mode = 2;
        wd = '{64'hDEAD, 64'hBEEF};
        session(0, 2, 0, 0, 0);
`ifdef EXT_MEM_HOST_DUMP_EN
        check("stall_cycles", 64'(stall_cnt), 64'd4);
`endif
        ready_mode = 0;

        // All counts zero
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1; n_instr = '0; n_data = '0; run_cycles = '0; s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (!done && guard < 10) begin @(negedge clk); guard++; end
        d = cyc;
        check("zero_done", 64'(done), 64'd1);
        check("zero_latency_le2", 64'((d - s) <= 2), 64'd1);
        check("zero_no_enable", 64'(en_cnt), 64'd0);

        // Oversized program request is clamped to the memory depth
        fill(600, 0);
        session(600, 0, 3, 0, 0);
        if (iw_q.size() > 0) check("clamp_last_addr", iw_q[iw_q.size() - 1][95:32], 64'h7FC);

        // start while busy must be ignored
        fill(2, 2);
        session(2, 2, 10, 1, 1);

        // Reset during the run, then a normal session
        fill(2, 2);
        session(2, 2, 40, 0, 2);
        fill(2, 3);
        session(2, 3, 4, -1, 0);

        // Random sessions with random stalls and back-pressure
        ready_mode = 1;
        for (int r = 0; r < 8; r++) begin
            int ni, nd, rc;
            ni = $urandom_range(0, 6);
            nd = $urandom_range(0, 6);
            rc = $urandom_range(0, 12);
            fill(ni, nd);
            session(ni, nd, rc, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
